keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 239 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - matrix keypad scanner with frame debounce and event FIFO
module keypad_scanner #(
    parameter int N_COLS     = 4,
    parameter int N_ROWS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = $clog2(N_COLS * N_ROWS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              scan_en_i,
    output logic [N_COLS-1:0] cols_o,
    input  logic [N_ROWS-1:0] rows_i,
    output logic              key_valid_o,
    input  logic              key_ready_i,
    output logic [CW-1:0]     key_code_o,
    output logic              is_num_o,
    output logic              is_op_o,
    output logic              is_eq_o,
    output logic              is_clr_o,
    output logic [3:0]        num_val_o,
    output logic [1:0]        op_val_o,
    output logic              key_held_o,
    output logic              overflow_o,
    input  logic              clr_ovf_i
);
    localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CIW = $clog2(N_COLS);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] NR = CW'(N_ROWS);
    localparam bit DEC_EN = (N_COLS == 4) && (N_ROWS == 4);

    typedef enum logic [1:0] {S_IDLE, S_CAND, S_PRESSED} state_t;

    logic [N_ROWS-1:0] sync1_q, sync2_q;
    logic [DW-1:0]     dwell_q;
    logic [CIW-1:0]    col_q;
    logic [1:0]        acc_n_q;
    logic [CW-1:0]     acc_code_q;
    state_t            state_q;
    logic [CW-1:0]     cand_q;
    logic [3:0]        cnt_q;

    logic          col_end, frame_end, f_none, f_single, fire;
    logic [1:0]    samp_n, tot_n;
    logic [2:0]    sum_n;
    logic [CW-1:0] samp_r, samp_code, tot_code, ev_c, ev_r;
    logic          ev_num, ev_op, ev_eq, ev_clr;
    logic [3:0]    ev_num_val;
    logic [1:0]    ev_op_val;

    always_comb begin
        cols_o = '0;
        if (scan_en_i) cols_o[col_q] = 1'b1;
    end

    // Frame result accumulates as a saturating bit count (0/1/many) plus the single code seen.
    always_comb begin
        col_end   = scan_en_i && (dwell_q == DW'(SCAN_DIV - 1));
        frame_end = col_end && (col_q == CIW'(N_COLS - 1));
        samp_n = 2'd0;
        samp_r = '0;
        for (int i = 0; i < N_ROWS; i++) begin
            if (sync2_q[i]) begin
                samp_r = CW'(i);
                if (samp_n != 2'd2) samp_n = samp_n + 2'd1;
            end
        end
        samp_code = CW'(col_q) * NR + samp_r;
        sum_n     = {1'b0, acc_n_q} + {1'b0, samp_n};
        tot_n     = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        tot_code  = (samp_n == 2'd1) ? samp_code : acc_code_q;
        f_none    = (tot_n == 2'd0);
        f_single  = (tot_n == 2'd1);
        fire      = frame_end && f_single &&
                    (((state_q == S_IDLE) && (DEBOUNCE == 1)) ||
                     ((state_q == S_CAND) && (tot_code == cand_q) &&
                      (cnt_q + 4'd1 == 4'(DEBOUNCE))));
    end

    always_comb begin
        ev_c       = tot_code / NR;
        ev_r       = tot_code % NR;
        ev_num     = 1'b0;
        ev_op      = 1'b0;
        ev_eq      = 1'b0;
        ev_clr     = 1'b0;
        ev_num_val = 4'd0;
        ev_op_val  = 2'd0;
        if (DEC_EN) begin
            if (ev_c < CW'(3) && ev_r < CW'(3)) begin
                ev_num     = 1'b1;
                ev_num_val = 4'(3 * ev_r + ev_c + 1);
            end else if (ev_c == CW'(1)) begin
                ev_num = 1'b1;
            end else if (ev_c == CW'(3)) begin
                ev_op     = 1'b1;
                ev_op_val = 2'(ev_r);
            end else if (ev_c == CW'(2)) begin
                ev_eq = 1'b1;
            end else begin
                ev_clr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            dwell_q    <= '0;
            col_q      <= '0;
            acc_n_q    <= 2'd0;
            acc_code_q <= '0;
        end else begin
            sync1_q <= rows_i;
            sync2_q <= sync1_q;
            if (!scan_en_i) begin
                dwell_q    <= '0;
                col_q      <= '0;
                acc_n_q    <= 2'd0;
                acc_code_q <= '0;
            end else if (col_end) begin
                dwell_q <= '0;
                if (frame_end) begin
                    col_q      <= '0;
                    acc_n_q    <= 2'd0;
                    acc_code_q <= '0;
                end else begin
                    col_q      <= col_q + CIW'(1);
                    acc_n_q    <= tot_n;
                    acc_code_q <= tot_code;
                end
            end else begin
                dwell_q <= dwell_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            cnt_q   <= 4'd0;
        end else if (!scan_en_i) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            cnt_q   <= 4'd0;
        end else if (frame_end) begin
            case (state_q)
                S_IDLE: if (f_single) begin
                    cand_q <= tot_code;
                    if (DEBOUNCE == 1) begin
                        state_q <= S_PRESSED;
                        cnt_q   <= 4'd0;
                    end else begin
                        state_q <= S_CAND;
                        cnt_q   <= 4'd1;
                    end
                end
                S_CAND: if (!f_single) begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                end else if (tot_code != cand_q) begin
                    cand_q <= tot_code;
                    cnt_q  <= 4'd1;
                end else if (fire) begin
                    state_q <= S_PRESSED;
                    cnt_q   <= 4'd0;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
                default: if (!f_none) begin
                    cnt_q <= 4'd0;
                end else if (cnt_q + 4'd1 == 4'(DEBOUNCE)) begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            endcase
        end
    end

    assign key_held_o = (state_q == S_PRESSED);

    logic [CW-1:0] mem_code [FIFO_DEPTH];
    logic [3:0]    mem_cls  [FIFO_DEPTH];
    logic [3:0]    mem_num  [FIFO_DEPTH];
    logic [1:0]    mem_op   [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   count_q;
    logic          full, pop, push_ok, drop;

    always_comb begin
        full    = (count_q == (PW + 1)'(FIFO_DEPTH));
        pop     = key_valid_o && key_ready_i;
        push_ok = fire && (!full || pop);
        drop    = fire && full && !pop;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_code[wr_q] <= tot_code;
            mem_cls[wr_q]  <= {ev_num, ev_op, ev_eq, ev_clr};
            mem_num[wr_q]  <= ev_num_val;
            mem_op[wr_q]   <= ev_op_val;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) wr_q <= wr_q + PW'(1);
            if (pop)     rd_q <= rd_q + PW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
            // A drop wins over a same-cycle clear so the loss is never hidden.
            if (drop)           overflow_o <= 1'b1;
            else if (clr_ovf_i) overflow_o <= 1'b0;
        end
    end

    always_comb begin
        key_valid_o = (count_q != '0);
        key_code_o  = key_valid_o ? mem_code[rd_q] : '0;
        {is_num_o, is_op_o, is_eq_o, is_clr_o} = key_valid_o ? mem_cls[rd_q] : 4'd0;
        num_val_o   = key_valid_o ? mem_num[rd_q] : 4'd0;
        op_val_o    = key_valid_o ? mem_op[rd_q] : 2'd0;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst_n, scan_en, key_ready, clr_ovf;
    logic [3:0]  cols, rows;
    logic        key_valid, is_num, is_op, is_eq, is_clr, key_held, overflow;
    logic [3:0]  key_code, num_val;
    logic [1:0]  op_val;
    logic [15:0] keys;
    int          checks = 0;
    int          errors = 0;
    int          ev_cnt = 0;

    keypad_scanner #(.N_COLS(4), .N_ROWS(4), .SCAN_DIV(4), .DEBOUNCE(3), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .scan_en_i(scan_en), .cols_o(cols), .rows_i(rows),
        .key_valid_o(key_valid), .key_ready_i(key_ready), .key_code_o(key_code),
        .is_num_o(is_num), .is_op_o(is_op), .is_eq_o(is_eq), .is_clr_o(is_clr),
        .num_val_o(num_val), .op_val_o(op_val), .key_held_o(key_held),
        .overflow_o(overflow), .clr_ovf_i(clr_ovf)
    );

    always #5 clk = ~clk;

    // Key (c,r) is bit c*4+r; a pressed key shorts its column strobe onto its row.
    always_comb begin
        rows = 4'd0;
        for (int c = 0; c < 4; c++)
            if (cols[c]) rows = rows | keys[c*4 +: 4];
    end

    always @(posedge clk)
        if (rst_n && key_valid && key_ready) ev_cnt++;

    task automatic start_scan();
        @(negedge clk); scan_en = 1'b0;
        @(negedge clk); scan_en = 1'b1;
    endtask

    task automatic run_frames(input logic [15:0] k, input int n);
        keys = k;
        repeat (16 * n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic saw_valid;
        rst_n = 1'b0; scan_en = 1'b1; key_ready = 1'b0; clr_ovf = 1'b0; keys = 16'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cols, key_valid, key_held, overflow} !== {4'b0001, 3'b000}) begin
            errors++; $display("FAIL reset_ctrl: got %b %b %b %b want 0001 0 0 0", cols, key_valid, key_held, overflow);
        end
        checks++;
        if ({key_code, is_num, is_op, is_eq, is_clr, num_val, op_val} !== 14'd0) begin
            errors++; $display("FAIL reset_payload: got %h %b%b%b%b %h %h want zeros", key_code, is_num, is_op, is_eq, is_clr, num_val, op_val);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] exp_cols;
            @(negedge clk);
            exp_cols = 4'b0001 << ((i / 4) % 4);
            checks++;
            if (cols !== exp_cols) begin
                errors++; $display("FAIL col_seq[%0d]: got %b want %b", i, cols, exp_cols);
            end
        end
        saw_valid = 1'b0;
        repeat (160) begin
            @(negedge clk);
            if (key_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0) begin
            errors++; $display("FAIL idle_no_event: got %b want 0", saw_valid);
        end
    endtask

    task automatic test_single_key();
        int base;
        key_ready = 1'b1;
        start_scan();
        base = ev_cnt;
        run_frames(16'h0200, 2);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL single_early: key_valid got %b want 0", key_valid);
        end
        run_frames(16'h0200, 1);
        checks++;
        if ({key_valid, key_code, is_num, is_op, is_eq, is_clr, num_val} !== {1'b1, 4'd9, 4'b1000, 4'd6}) begin
            errors++; $display("FAIL single_event: got v=%b code=%0d cls=%b%b%b%b num=%0d want v=1 code=9 cls=1000 num=6",
                                key_valid, key_code, is_num, is_op, is_eq, is_clr, num_val);
        end
        run_frames(16'h0200, 2);
        checks++;
        if ({key_held, 32'(ev_cnt - base)} !== {1'b1, 32'd1}) begin
            errors++; $display("FAIL single_held: got held=%b events=%0d want held=1 events=1", key_held, ev_cnt - base);
        end
        run_frames(16'h0000, 2);
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL release_2: key_held got %b want 1", key_held);
        end
        run_frames(16'h0000, 1);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL release_3: key_held got %b want 0", key_held);
        end
    endtask

    task automatic test_bounce();
        int base;
        start_scan();
        base = ev_cnt;
        run_frames(16'h1000, 2);
        run_frames(16'h0000, 1);
        run_frames(16'h1000, 2);
        checks++;
        if ({key_valid, 32'(ev_cnt - base)} !== {1'b0, 32'd0}) begin
            errors++; $display("FAIL bounce_early: got v=%b events=%0d want v=0 events=0", key_valid, ev_cnt - base);
        end
        run_frames(16'h1000, 1);
        checks++;
        if ({key_valid, key_code, is_op, is_num, op_val} !== {1'b1, 4'd12, 2'b10, 2'd0}) begin
            errors++; $display("FAIL bounce_event: got v=%b code=%0d op=%b num=%b opv=%0d want v=1 code=12 op=1 num=0 opv=0",
                                key_valid, key_code, is_op, is_num, op_val);
        end
        run_frames(16'h0000, 3);
        checks++;
        if (32'(ev_cnt - base) !== 32'd1) begin
            errors++; $display("FAIL bounce_count: got %0d events want 1", ev_cnt - base);
        end
    endtask

    task automatic test_multi();
        int base;
        start_scan();
        base = ev_cnt;
        run_frames(16'h0011, 5);
        checks++;
        if ({key_valid, key_held, 32'(ev_cnt - base)} !== {2'b00, 32'd0}) begin
            errors++; $display("FAIL multi_key: got v=%b held=%b events=%0d want 0 0 0", key_valid, key_held, ev_cnt - base);
        end
        run_frames(16'h0000, 1);
    endtask

    task automatic test_overflow();
        logic [3:0] exp_code [5];
        logic [9:0] exp_cls  [4];
        exp_code = '{4'd3, 4'd1, 4'd5, 4'd13, 4'd10};
        exp_cls  = '{10'b0001_0000_00, 10'b1000_0100_00, 10'b1000_0101_00, 10'b0100_0000_01};
        key_ready = 1'b0;
        start_scan();
        for (int i = 0; i < 5; i++) begin
            logic [15:0] k;
            k = 16'd1 << exp_code[i];
            run_frames(k, 3);
            run_frames(16'h0000, 3);
        end
        checks++;
        if ({key_valid, overflow} !== 2'b11) begin
            errors++; $display("FAIL ovf_set: got v=%b ovf=%b want 1 1", key_valid, overflow);
        end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (key_code !== exp_code[i]) begin
                errors++; $display("FAIL fifo_code[%0d]: got %0d want %0d", i, key_code, exp_code[i]);
            end
            checks++;
            if ({is_num, is_op, is_eq, is_clr, num_val, op_val} !== exp_cls[i]) begin
                errors++; $display("FAIL fifo_class[%0d]: got %b want %b", i, {is_num, is_op, is_eq, is_clr, num_val, op_val}, exp_cls[i]);
            end
            key_ready = 1'b1;
            @(negedge clk);
            key_ready = 1'b0;
        end
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL fifo_drained: key_valid got %b want 0", key_valid);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        key_ready = 1'b1;
        start_scan();
        base = ev_cnt;
        run_frames(16'h0200, 2);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cols, key_valid, key_held, overflow, key_code} !== {4'b0001, 3'b000, 4'd0}) begin
            errors++; $display("FAIL mid_reset: got cols=%b v=%b held=%b ovf=%b code=%0d want 0001 0 0 0 0",
                                cols, key_valid, key_held, overflow, key_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_frames(16'h0200, 2);
        checks++;
        if ({key_valid, 32'(ev_cnt - base)} !== {1'b0, 32'd0}) begin
            errors++; $display("FAIL mid_reset_no_event: got v=%b events=%0d want 0 0", key_valid, ev_cnt - base);
        end
        scan_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({cols, key_held} !== 5'b0000_0) begin
            errors++; $display("FAIL scan_disable: got cols=%b held=%b want 0000 0", cols, key_held);
        end
        keys = 16'd0;
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_bounce();
        test_multi();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
